costas_lpf_sched: RTL and testbench
===================================

# costas_lpf_sched

Time-shares one FIR low-pass engine between the I and Q arms of the Costas loop. Each arm presents 16-bit samples with a new-data strobe. The scheduler buffers one sample per arm, arbitrates round-robin, and issues samples to the shared engine with a channel tag. It routes each 36-bit engine result back to its arm as a 16-bit sliced output. It sits between the phase-detector mixers and the loop-filter error computation, replacing two separate LPF instances.

## Interface
- DW, 16: sample width (input and output).
- AW, 36: engine accumulator width.
- SHIFT, 20: LSB index of the output slice; output is acc[SHIFT+DW-1:SHIFT].
- TAG_DEPTH, 4: in-flight result capacity (power of two).

- CLK  in  1  clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- I_DIN  in  DW  I-arm sample.
- I_ND  in  1  I-arm new data, one-cycle strobe.
- Q_DIN  in  DW  Q-arm sample.
- Q_ND  in  1  Q-arm new data, one-cycle strobe.
- OVF_CLR  in  1  clears the sticky flags.
- FIR_DIN  out  DW  sample to engine.
- FIR_CH  out  1  engine channel select (0=I, 1=Q) for the state/coefficient bank.
- FIR_ND  out  1  sample valid to engine; held until accepted.
- FIR_RFD  in  1  engine ready for data; handshake completes when FIR_ND and FIR_RFD are both high.
- FIR_DOUT  in  AW  engine result.
- FIR_RDY  in  1  engine result valid; results return in issue order.
- I_DOUT / Q_DOUT  out  DW  filtered outputs, held between updates.
- I_VLD / Q_VLD  out  1  one-cycle output strobes.
- OVF  out  2  sticky input overrun, bit0=I, bit1=Q.
- ERR  out  1  sticky: FIR_RDY received with no tag in flight.

## Operation
- Holding registers: one per arm, each with a full flag.
  - ND loads the sample and sets full.
  - ND while full overwrites the sample and sets the OVF bit.
  - ND in the same cycle that arm is accepted by the engine is not an overrun: the new sample loads and full stays set.
- FSM states: ARB and ISSUE.
  - ARB: if any holding register is full and the tag FIFO is not full, grant and go to ISSUE. The grant loads FIR_DIN/FIR_CH from the holding register and clears its full flag. Otherwise stay in ARB.
  - ISSUE: FIR_ND=1 with FIR_DIN/FIR_CH stable. When FIR_RFD=1, push FIR_CH into the tag FIFO and return to ARB. Otherwise stay in ISSUE.
- Round-robin arbitration: when both arms are pending, grant the arm not granted last. The first grant after reset goes to I.
- Tag FIFO:
  - FIR_RDY pops the head tag and routes FIR_DOUT to that arm.
  - FIR_RDY with the FIFO empty: discard the result and set ERR.
  - Push and pop in the same cycle are both honoured.
- Output slice: acc[SHIFT+DW-1:SHIFT], truncation by default (see Configuration).
- OVF_CLR clears OVF and ERR. A flag event in the same cycle as OVF_CLR wins (the flag ends set).
- Reset clears every output, FSM state (to ARB), full flags, tag FIFO, round-robin pointer (to I), OVF and ERR.
  - All outputs are 0 in reset: FIR_DIN, FIR_CH, FIR_ND, I_DOUT, Q_DOUT, I_VLD, Q_VLD, OVF, ERR.
  - Reset mid-operation drops held samples and in-flight tags. Engine results arriving afterwards set ERR.

## Timing
- ND at edge N: holding register full at N+1, grant at N+1 (ARB), FIR_ND high from N+2.
- Throughput: one issue per 2 cycles with FIR_RFD held high.
- FIR_RDY at edge M: xDOUT updated and xVLD high for the cycle after M, so output is registered with 1-cycle latency.
- Tag FIFO full: ARB stalls; no FIR_ND until a pop occurs.

## Configuration
- COSTAS_LPF_ROUND_EN defined:
  - Add 2^(SHIFT-1) to the accumulator, then saturate to the signed DW range before slicing.
  - Adds one pipeline stage, so output latency becomes 2 cycles after FIR_RDY.
- Not defined: plain truncation, 1-cycle latency.

## Structure
- Shared package costas_pkg holds:
  - channel enum (CH_I=0, CH_Q=1);
  - FSM state enum;
  - default DW/AW/SHIFT constants.
- Sub-module costas_tag_fifo: synchronous FIFO, width 1, depth TAG_DEPTH, with full/empty flags.

## Test plan
- Single I sample 0x1234, RFD=1; engine returns 36'h0_1234_0000 two cycles later → FIR_CH=0; I_DOUT=0x1234 sliced (acc>>20=0x0123) with I_VLD one cycle; Q_VLD stays 0.
- I_ND and Q_ND in the same cycle → issue order I then Q; a second simultaneous pair issues I then Q again (round-robin alternates from last grant).
- I_ND twice before issue with RFD=0 → OVF=2'b01; the second value is issued; OVF_CLR then clears it to 0.
- RFD held 0 for 5 cycles → FIR_ND and FIR_DIN stable throughout; exactly one tag pushed when RFD rises.
- Four issues with no FIR_RDY → fifth sample waits in ARB; one FIR_RDY → fifth issued next cycles.
- FIR_RDY with no tag → ERR=1. With COSTAS_LPF_ROUND_EN defined, acc=36'h7_FFFF_FFFF → output 0x7FFF saturated.

Source files
------------

// File: rtl/costas_pkg.sv
// rtl/costas_pkg.sv - shared types and default widths for the Costas LPF scheduler
package costas_pkg;

    localparam int DW_DEF        = 16;
    localparam int AW_DEF        = 36;
    localparam int SHIFT_DEF     = 20;
    localparam int TAG_DEPTH_DEF = 4;

    typedef enum logic {
        CH_I = 1'b0,
        CH_Q = 1'b1
    } ch_e;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

endpackage

// File: rtl/costas_lpf_sched_if.sv
// rtl/costas_lpf_sched_if.sv - arm, engine and status signals of the LPF scheduler
interface costas_lpf_sched_if
    import costas_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);
    logic [DW-1:0] i_din;
    logic          i_nd;
    logic [DW-1:0] q_din;
    logic          q_nd;
    logic          ovf_clr;
    logic [DW-1:0] fir_din;
    logic          fir_ch;
    logic          fir_nd;
    logic          fir_rfd;
    logic [AW-1:0] fir_dout;
    logic          fir_rdy;
    logic [DW-1:0] i_dout;
    logic [DW-1:0] q_dout;
    logic          i_vld;
    logic          q_vld;
    logic [1:0]    ovf;
    logic          err;

    modport slave (
        input  i_din, i_nd, q_din, q_nd, ovf_clr, fir_rfd, fir_dout, fir_rdy,
        output fir_din, fir_ch, fir_nd, i_dout, q_dout, i_vld, q_vld, ovf, err
    );

    modport master (
        output i_din, i_nd, q_din, q_nd, ovf_clr, fir_rfd, fir_dout, fir_rdy,
        input  fir_din, fir_ch, fir_nd, i_dout, q_dout, i_vld, q_vld, ovf, err
    );

endinterface

// File: rtl/costas_tag_fifo.sv
// rtl/costas_tag_fifo.sv - 1-bit channel tag FIFO tracking in-flight engine results
module costas_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_push,
    input  logic i_din,
    input  logic i_pop,
    output logic o_dout,
    output logic o_full,
    output logic o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [PW:0]      r_wptr;
    logic [PW:0]      r_rptr;
    logic             w_wr;
    logic             w_rd;

    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign o_dout  = r_mem[r_rptr[PW-1:0]];

    // Storage and pointers; an extra pointer bit separates full from empty
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr[PW-1:0]] <= i_din;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/costas_lpf_sched.sv
// rtl/costas_lpf_sched.sv - I/Q round-robin scheduler for a shared FIR LPF (option: COSTAS_LPF_ROUND_EN)
module costas_lpf_sched
    import costas_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int AW        = AW_DEF,
    parameter int SHIFT     = SHIFT_DEF,
    parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    costas_lpf_sched_if.slave bus
);
    state_e        r_state;
    state_e        w_state_nxt;
    logic          w_grant;
    ch_e           w_grant_ch;
    ch_e           r_rr_next;
    ch_e           r_fir_ch;
    logic [DW-1:0] r_fir_din;
    logic [DW-1:0] r_hold_i;
    logic [DW-1:0] r_hold_q;
    logic          r_full_i;
    logic          r_full_q;
    logic          w_take_i;
    logic          w_take_q;
    logic [1:0]    r_ovf;
    logic          r_err;
    logic [1:0]    w_ovf_evt;
    logic          w_push;
    logic          w_pop;
    logic          w_orphan;
    logic          w_head;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_res_vld;
    logic          w_res_ch;
    logic [DW-1:0] w_res_data;
    logic [DW-1:0] r_i_dout;
    logic [DW-1:0] r_q_dout;
    logic          r_i_vld;
    logic          r_q_vld;

    assign w_take_i  = w_grant && (w_grant_ch == CH_I);
    assign w_take_q  = w_grant && (w_grant_ch == CH_Q);
    assign w_push    = (r_state == ST_ISSUE) && bus.fir_rfd;
    assign w_pop     = bus.fir_rdy && !w_fifo_empty;
    assign w_orphan  = bus.fir_rdy && w_fifo_empty;
    // A sample arriving while its arm is being granted simply refills the slot
    assign w_ovf_evt = {bus.q_nd && r_full_q && !w_take_q,
                        bus.i_nd && r_full_i && !w_take_i};

    assign bus.fir_nd  = (r_state == ST_ISSUE);
    assign bus.fir_din = r_fir_din;
    assign bus.fir_ch  = r_fir_ch;
    assign bus.i_dout  = r_i_dout;
    assign bus.q_dout  = r_q_dout;
    assign bus.i_vld   = r_i_vld;
    assign bus.q_vld   = r_q_vld;
    assign bus.ovf     = r_ovf;
    assign bus.err     = r_err;

    costas_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_din   (r_fir_ch),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_ARB;
        else          r_state <= w_state_nxt;
    end

    // Arbitration: grant only when a tag slot is free for the result
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_ch  = CH_I;
        case (r_state)
            ST_ARB: begin
                if ((r_full_i || r_full_q) && !w_fifo_full) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                    if (r_full_i && r_full_q) w_grant_ch = r_rr_next;
                    else if (r_full_q)        w_grant_ch = CH_Q;
                end
            end
            ST_ISSUE: begin
                if (bus.fir_rfd) w_state_nxt = ST_ARB;
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    // Per-arm holding registers with full flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold_i <= '0;
            r_hold_q <= '0;
            r_full_i <= 1'b0;
            r_full_q <= 1'b0;
        end else begin
            if (bus.i_nd) begin
                r_hold_i <= bus.i_din;
                r_full_i <= 1'b1;
            end else if (w_take_i) begin
                r_full_i <= 1'b0;
            end
            if (bus.q_nd) begin
                r_hold_q <= bus.q_din;
                r_full_q <= 1'b1;
            end else if (w_take_q) begin
                r_full_q <= 1'b0;
            end
        end
    end

    // Capture the granted sample for the engine and advance the round-robin pointer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fir_din <= '0;
            r_fir_ch  <= CH_I;
            r_rr_next <= CH_I;
        end else if (w_grant) begin
            r_fir_din <= (w_grant_ch == CH_Q) ? r_hold_q : r_hold_i;
            r_fir_ch  <= w_grant_ch;
            r_rr_next <= (w_grant_ch == CH_I) ? CH_Q : CH_I;
        end
    end

    // Sticky flags; a new event beats a simultaneous clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= '0;
            r_err <= 1'b0;
        end else begin
            r_ovf <= (bus.ovf_clr ? 2'b00 : r_ovf) | w_ovf_evt;
            r_err <= (bus.ovf_clr ? 1'b0 : r_err) | w_orphan;
        end
    end

`ifdef COSTAS_LPF_ROUND_EN
    localparam logic signed [AW:0] RND     = {{AW{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [AW:0] SAT_MAX = (AW + 1)'((1 << (DW - 1)) - 1);
    localparam logic signed [AW:0] SAT_MIN = ~SAT_MAX;

    logic signed [AW:0] w_rnd_sum;
    logic signed [AW:0] w_rnd_shr;
    logic [DW-1:0]      w_sat;
    logic [DW-1:0]      r_p_data;
    logic               r_p_vld;
    logic               r_p_ch;

    // One extra bit of headroom so the rounding add cannot wrap
    assign w_rnd_sum = $signed({bus.fir_dout[AW-1], bus.fir_dout}) + RND;
    assign w_rnd_shr = w_rnd_sum >>> SHIFT;

    // Clamp the rounded value to the signed output range
    always_comb begin
        w_sat = DW'(w_rnd_shr);
        if (w_rnd_shr > SAT_MAX)      w_sat = DW'(SAT_MAX);
        else if (w_rnd_shr < SAT_MIN) w_sat = DW'(SAT_MIN);
    end

    // Rounding pipeline stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p_data <= '0;
            r_p_vld  <= 1'b0;
            r_p_ch   <= 1'b0;
        end else begin
            r_p_data <= w_sat;
            r_p_vld  <= w_pop;
            r_p_ch   <= w_head;
        end
    end

    assign w_res_vld  = r_p_vld;
    assign w_res_ch   = r_p_ch;
    assign w_res_data = r_p_data;
`else
    assign w_res_vld  = w_pop;
    assign w_res_ch   = w_head;
    assign w_res_data = DW'(bus.fir_dout >> SHIFT);
`endif

    // Route each result to its arm and strobe that arm for one cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_i_dout <= '0;
            r_q_dout <= '0;
            r_i_vld  <= 1'b0;
            r_q_vld  <= 1'b0;
        end else begin
            r_i_vld <= w_res_vld && (w_res_ch == CH_I);
            r_q_vld <= w_res_vld && (w_res_ch == CH_Q);
            if (w_res_vld && (w_res_ch == CH_I)) r_i_dout <= w_res_data;
            if (w_res_vld && (w_res_ch == CH_Q)) r_q_dout <= w_res_data;
        end
    end

endmodule

// File: tb/tb_costas_lpf_sched.sv
// tb/tb_costas_lpf_sched.sv - directed vector bench for costas_lpf_sched
module tb_costas_lpf_sched;
    import costas_pkg::*;

    localparam int DW = 16;
    localparam int AW = 36;
`ifdef COSTAS_LPF_ROUND_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic          ch;
        logic [DW-1:0] din;
        logic [AW-1:0] acc;
        logic [DW-1:0] exp_trunc;
        logic [DW-1:0] exp_round;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    vec_t vecs[8];

    always #5 clk = ~clk;

    costas_lpf_sched_if #(.DW(DW), .AW(AW)) bus ();

    costas_lpf_sched #(.DW(DW), .AW(AW), .SHIFT(20), .TAG_DEPTH(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_nd(input logic ch, input logic [DW-1:0] d);
        if (ch) begin bus.q_din = d; bus.q_nd = 1'b1; end
        else    begin bus.i_din = d; bus.i_nd = 1'b1; end
        tick();
        bus.i_nd = 1'b0;
        bus.q_nd = 1'b0;
    endtask

    task automatic wait_fir_nd(input string name, input int budget);
        int k = 0;
        while (!bus.fir_nd && k < budget) begin tick(); k++; end
        check(name, 64'(bus.fir_nd), 64'd1);
    endtask

    task automatic issue_one(input logic ch, input logic [DW-1:0] d, input string name);
        pulse_nd(ch, d);
        wait_fir_nd({name, "_nd"}, 10);
        check({name, "_ch"}, 64'(bus.fir_ch), 64'(ch));
        check({name, "_din"}, 64'(bus.fir_din), 64'(d));
        bus.fir_rfd = 1'b1;
        tick();
        bus.fir_rfd = 1'b0;
    endtask

    task automatic return_result(input logic ch, input logic [AW-1:0] acc,
                                 input logic [DW-1:0] exp, input string name);
        int lat = 1;
        bus.fir_dout = acc;
        bus.fir_rdy  = 1'b1;
        tick();
        bus.fir_rdy  = 1'b0;
        while (!(ch ? bus.q_vld : bus.i_vld) && lat < 4) begin tick(); lat++; end
        check({name, "_lat"}, 64'(lat), 64'(LAT));
        check({name, "_dout"}, 64'(ch ? bus.q_dout : bus.i_dout), 64'(exp));
        check({name, "_other_vld"}, 64'(ch ? bus.i_vld : bus.q_vld), 64'd0);
        tick();
        check({name, "_vld_drop"}, 64'(ch ? bus.q_vld : bus.i_vld), 64'd0);
    endtask

    task automatic rr_pair(input string name);
        int got = 0;
        logic [1:0] order = 2'b11;
        bus.i_din = 16'h0101;
        bus.q_din = 16'h0202;
        bus.i_nd  = 1'b1;
        bus.q_nd  = 1'b1;
        tick();
        bus.i_nd    = 1'b0;
        bus.q_nd    = 1'b0;
        bus.fir_rfd = 1'b1;
        for (int k = 0; k < 12 && got < 2; k++) begin
            if (bus.fir_nd) begin order[got] = bus.fir_ch; got++; end
            tick();
        end
        bus.fir_rfd = 1'b0;
        check({name, "_count"}, 64'(got), 64'd2);
        check({name, "_first"}, 64'(order[0]), 64'd0);
        check({name, "_second"}, 64'(order[1]), 64'd1);
        return_result(1'b0, 36'h0_0010_0000, 16'h0001, {name, "_ri"});
        return_result(1'b1, 36'h0_0010_0000, 16'h0001, {name, "_rq"});
    endtask

    initial begin
        logic [DW-1:0] exp;

        vecs[0] = '{1'b0, 16'h1234, 36'h0_1234_0000, 16'h0123, 16'h0123};
        vecs[1] = '{1'b1, 16'hBEEF, 36'h0_0018_0000, 16'h0001, 16'h0002};
        vecs[2] = '{1'b0, 16'h7FFF, 36'h7_FFFF_FFFF, 16'h7FFF, 16'h7FFF};
        vecs[3] = '{1'b1, 16'h8000, 36'h8_0000_0000, 16'h8000, 16'h8000};
        vecs[4] = '{1'b0, 16'h0F0F, 36'hF_FFF0_0000, 16'hFFFF, 16'hFFFF};
        vecs[5] = '{1'b1, 16'h0001, 36'h1_0000_0000, 16'h1000, 16'h1000};
        vecs[6] = '{1'b0, 16'hA5A5, 36'h0_0008_0000, 16'h0000, 16'h0001};
        vecs[7] = '{1'b1, 16'h5A5A, 36'h7_FFF8_0000, 16'h7FFF, 16'h7FFF};

        bus.i_din = '0; bus.i_nd = 1'b0; bus.q_din = '0; bus.q_nd = 1'b0;
        bus.ovf_clr = 1'b0; bus.fir_rfd = 1'b0; bus.fir_dout = '0; bus.fir_rdy = 1'b0;

        // reset state
        repeat (3) tick();
        check("rst_fir_nd", 64'(bus.fir_nd), 64'd0);
        check("rst_fir_din", 64'(bus.fir_din), 64'd0);
        check("rst_fir_ch", 64'(bus.fir_ch), 64'd0);
        check("rst_vld", 64'({bus.i_vld, bus.q_vld}), 64'd0);
        check("rst_dout", 64'({bus.i_dout, bus.q_dout}), 64'd0);
        check("rst_flags", 64'({bus.ovf, bus.err}), 64'd0);
        rst_n = 1'b1;
        tick();

        // slice vectors
        for (int v = 0; v < 8; v++) begin
`ifdef COSTAS_LPF_ROUND_EN
            exp = vecs[v].exp_round;
`else
            exp = vecs[v].exp_trunc;
`endif
            issue_one(vecs[v].ch, vecs[v].din, $sformatf("vec%0d", v));
            return_result(vecs[v].ch, vecs[v].acc, exp, $sformatf("vec%0d", v));
        end
        check("vec_err", 64'(bus.err), 64'd0);

        // simultaneous requests alternate I then Q
        rr_pair("rr1");
        rr_pair("rr2");

        // overrun while engine busy
        pulse_nd(1'b1, 16'h3333);
        wait_fir_nd("ovr_q_nd", 10);
        pulse_nd(1'b0, 16'h1111);
        pulse_nd(1'b0, 16'h2222);
        check("ovr_flag", 64'(bus.ovf), 64'd1);
        check("ovr_hold_din", 64'(bus.fir_din), 64'h3333);
        bus.fir_rfd = 1'b1;
        tick();
        bus.fir_rfd = 1'b0;
        wait_fir_nd("ovr_i_nd", 10);
        check("ovr_i_ch", 64'(bus.fir_ch), 64'd0);
        check("ovr_i_din", 64'(bus.fir_din), 64'h2222);
        bus.fir_rfd = 1'b1;
        tick();
        bus.fir_rfd = 1'b0;
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovr_clr", 64'(bus.ovf), 64'd0);
        return_result(1'b1, 36'h0_0040_0000, 16'h0004, "ovr_rq");
        return_result(1'b0, 36'h0_0050_0000, 16'h0005, "ovr_ri");

        // RFD stall keeps the sample stable; exactly one tag results
        pulse_nd(1'b0, 16'h4444);
        wait_fir_nd("stall_nd", 10);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall_nd_c%0d", k), 64'(bus.fir_nd), 64'd1);
            check($sformatf("stall_din_c%0d", k), 64'(bus.fir_din), 64'h4444);
            tick();
        end
        bus.fir_rfd = 1'b1;
        tick();
        bus.fir_rfd = 1'b0;
        return_result(1'b0, 36'h0_0020_0000, 16'h0002, "stall_r");
        check("stall_err0", 64'(bus.err), 64'd0);
        // orphan result together with a clear: the error still lands
        bus.fir_dout = 36'h0_0070_0000;
        bus.fir_rdy  = 1'b1;
        bus.ovf_clr  = 1'b1;
        tick();
        bus.fir_rdy  = 1'b0;
        bus.ovf_clr  = 1'b0;
        check("orphan_err", 64'(bus.err), 64'd1);
        tick();
        tick();
        check("orphan_no_vld", 64'({bus.i_vld, bus.q_vld}), 64'd0);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("err_clr", 64'(bus.err), 64'd0);

        // tag FIFO full stalls the fifth issue
        for (int k = 0; k < 4; k++) issue_one(1'b0, 16'(16'h5000 + k), $sformatf("full%0d", k));
        pulse_nd(1'b0, 16'h5555);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("full_stall_c%0d", k), 64'(bus.fir_nd), 64'd0);
            tick();
        end
        return_result(1'b0, 36'h0_0030_0000, 16'h0003, "full_pop");
        wait_fir_nd("full_fifth_nd", 6);
        check("full_fifth_din", 64'(bus.fir_din), 64'h5555);
        bus.fir_rfd = 1'b1;
        tick();
        bus.fir_rfd = 1'b0;
        for (int k = 0; k < 4; k++) return_result(1'b0, 36'h0_0030_0000, 16'h0003, $sformatf("drain%0d", k));
        check("full_err", 64'(bus.err), 64'd0);

        // reset mid-operation drops the held sample and in-flight tag
        issue_one(1'b1, 16'h6666, "mid");
        pulse_nd(1'b0, 16'h7777);
        rst_n = 1'b0;
        #1;
        check("mid_rst_nd", 64'(bus.fir_nd), 64'd0);
        check("mid_rst_din", 64'(bus.fir_din), 64'd0);
        check("mid_rst_dout", 64'({bus.i_dout, bus.q_dout}), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("mid_idle_c%0d", k), 64'(bus.fir_nd), 64'd0);
            tick();
        end
        bus.fir_dout = 36'h0_0010_0000;
        bus.fir_rdy  = 1'b1;
        tick();
        bus.fir_rdy  = 1'b0;
        check("mid_err", 64'(bus.err), 64'd1);
        tick();
        tick();
        check("mid_no_vld", 64'({bus.i_vld, bus.q_vld}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
